// File: rtl/mem_ctrl.sv
// Line-oriented memory model behind a cache: 2-byte-wide beat bus, fixed response latency,
// tri-stated shared command/data buses driven only while responding.
module mem_ctrl #(
  parameter int unsigned ADDR2_BUS_SIZE  = 10,
  parameter int unsigned DATA_BUS_SIZE   = 16,
  parameter int unsigned CTR2_BUS_SIZE   = 2,
  parameter int unsigned CACHE_LINE_SIZE = 16,
  parameter int unsigned MEM_LATENCY     = 100
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [ADDR2_BUS_SIZE-1:0] A2_WIRE,
  inout  wire logic [DATA_BUS_SIZE-1:0] D2_WIRE,
  inout  wire logic [CTR2_BUS_SIZE-1:0] C2_WIRE
);

  localparam int unsigned BEATS  = CACHE_LINE_SIZE / 2;
  localparam int unsigned LINE_W = BEATS * DATA_BUS_SIZE;
  localparam int unsigned DEPTH  = 2 ** ADDR2_BUS_SIZE;
  localparam int unsigned CNT_W  = $clog2(MEM_LATENCY);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(2'b00);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(2'b01);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2'b10);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(2'b11);

  if (MEM_LATENCY < BEATS + 1) begin : g_latency_check
    $error("mem_ctrl: MEM_LATENCY must be at least BEATS+1");
  end

  typedef enum logic [2:0] {IDLE, WR_RX, WAIT, RD_TX, WR_ACK} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [ADDR2_BUS_SIZE-1:0] addr_q, addr_d;
  logic                      is_wr_q, is_wr_d;
  logic [LINE_W-1:0]         buf_q, buf_d;
  logic                      mem_we;
  logic                      drive_c2, drive_d2;
  logic [DATA_BUS_SIZE-1:0]  rd_word;

  // Array is deliberately outside the reset domain so contents survive RESET_N.
  logic [LINE_W-1:0] mem_q [DEPTH];

  assign rd_word = mem_q[addr_q][int'(beat_q) * DATA_BUS_SIZE +: DATA_BUS_SIZE];

  assign C2_WIRE = drive_c2 ? C2_RESPONSE : {CTR2_BUS_SIZE{1'bz}};
  assign D2_WIRE = drive_d2 ? rd_word : {DATA_BUS_SIZE{1'bz}};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    is_wr_d  = is_wr_q;
    buf_d    = buf_q;
    mem_we   = 1'b0;
    drive_c2 = 1'b0;
    drive_d2 = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (C2_WIRE == C2_READ_LINE) begin
          addr_d  = A2_WIRE;
          cnt_d   = CNT_LOAD;
          is_wr_d = 1'b0;
          beat_d  = '0;
          state_d = WAIT;
        end else if (C2_WIRE == C2_WRITE_LINE) begin
          addr_d                     = A2_WIRE;
          cnt_d                      = CNT_LOAD;
          is_wr_d                    = 1'b1;
          buf_d[DATA_BUS_SIZE-1:0]   = D2_WIRE;
          beat_d                     = BEAT_W'(1);
          state_d                    = WR_RX;
        end
      end
      WR_RX: begin
        cnt_d = cnt_q - 1'b1;
        buf_d[int'(beat_q) * DATA_BUS_SIZE +: DATA_BUS_SIZE] = D2_WIRE;
        if (beat_q == LAST_BEAT) begin
          mem_we  = 1'b1;
          beat_d  = '0;
          state_d = WAIT;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      WAIT: begin
        // Counter was loaded with LATENCY-1 on the command edge; zero means this edge starts
        // the response cycle.
        if (cnt_q == '0) begin
          beat_d  = '0;
          state_d = is_wr_q ? WR_ACK : RD_TX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_TX: begin
        drive_c2 = 1'b1;
        drive_d2 = 1'b1;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      WR_ACK: begin
        drive_c2 = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      is_wr_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      is_wr_q <= is_wr_d;
      buf_q   <= buf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[addr_q] <= buf_d;
    end
  end

  logic unused_nop;
  assign unused_nop = ^C2_NOP;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: commands push expected bus responses, a negedge monitor
// pops and compares them; floating buses read as C2=00 / D2=FFFF through the net pulls.
module tb_mem_ctrl;

  localparam int unsigned LAT   = 100;
  localparam int unsigned BEATS = 8;

  typedef struct {
    int          cyc;
    logic [15:0] d2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  a2 = '0;
  logic [15:0] tb_d2 = '0;
  logic        tb_d2_en = 1'b0;
  logic [1:0]  tb_c2 = '0;
  logic        tb_c2_en = 1'b0;

  tri1 [15:0] d2_w;
  tri0 [1:0]  c2_w;

  assign d2_w = tb_d2_en ? tb_d2 : 16'hzzzz;
  assign c2_w = tb_c2_en ? tb_c2 : 2'bzz;

  mem_ctrl #(
    .ADDR2_BUS_SIZE (10),
    .DATA_BUS_SIZE  (16),
    .CTR2_BUS_SIZE  (2),
    .CACHE_LINE_SIZE(16),
    .MEM_LATENCY    (LAT)
  ) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .A2_WIRE(a2),
    .D2_WIRE(d2_w),
    .C2_WIRE(c2_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] mdl [int];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] ramp(input logic [7:0] base);
    logic [127:0] r;
    for (int i = 0; i < BEATS; i++) begin
      r[i*16 +: 16] = {base + 8'(2 * i + 1), base + 8'(2 * i)};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() != 0 && sb[0].cyc < cyc) begin
        check("missing_rsp", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (c2_w == 2'b01) begin
        if (sb.size() == 0) begin
          check("spurious_rsp", 32'(c2_w), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_cycle", cyc, mon_e.cyc);
          check("rsp_d2", 32'(d2_w), 32'(mon_e.d2));
        end
      end else begin
        if (!tb_c2_en) check("idle_c2", 32'(c2_w), 32'h0);
        if (!tb_d2_en) check("idle_d2", 32'(d2_w), 32'hFFFF);
      end
    end
  end

  // All stimulus tasks start and end at negedge+1.
  task automatic cmd_read(input logic [9:0] a, input bit expect_rsp);
    logic [127:0] line;
    tb_c2    = 2'b10;
    tb_c2_en = 1'b1;
    a2       = a;
    if (expect_rsp) begin
      line = mdl[int'(a)];
      for (int i = 0; i < BEATS; i++) sb.push_back('{cyc + 1 + LAT + i, line[i*16 +: 16]});
    end
    @(negedge clk); #1;
    tb_c2_en = 1'b0;
  endtask

  task automatic cmd_write(input logic [9:0] a, input logic [127:0] line);
    tb_c2    = 2'b11;
    tb_c2_en = 1'b1;
    a2       = a;
    tb_d2    = line[15:0];
    tb_d2_en = 1'b1;
    sb.push_back('{cyc + 1 + LAT, 16'hFFFF});
    for (int i = 1; i < BEATS; i++) begin
      @(negedge clk); #1;
      tb_c2_en = 1'b0;
      tb_d2    = line[i*16 +: 16];
    end
    @(negedge clk); #1;
    tb_d2_en = 1'b0;
    mdl[int'(a)] = line;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
    sb.delete();
    @(negedge clk); #1;
  endtask

  logic [127:0] line_x;
  int           start;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_c2", 32'(c2_w), 32'h0);
    check("rst_d2", 32'(d2_w), 32'hFFFF);

    // Command on the first edge after release; then read it back.
    rst_n = 1'b1;
    cmd_write(10'h005, ramp(8'h00));
    wait_idle();
    cmd_read(10'h005, 1'b1);
    wait_idle();

    // Read issued in the cycle right after WR_ACK.
    line_x = {$urandom, $urandom, $urandom, $urandom};
    cmd_write(10'h0AA, line_x);
    wait_idle();
    cmd_read(10'h0AA, 1'b1);
    wait_idle();

    // Second command during WAIT must be dropped.
    cmd_read(10'h005, 1'b1);
    repeat (20) @(negedge clk);
    #1;
    cmd_read(10'h0AA, 1'b0);
    wait_idle();

    // Reset at beat 4 of a write: line keeps its earlier contents.
    cmd_write(10'h3FF, ramp(8'h40));
    wait_idle();
    line_x   = ramp(8'h80);
    tb_c2    = 2'b11;
    tb_c2_en = 1'b1;
    a2       = 10'h3FF;
    tb_d2    = line_x[15:0];
    tb_d2_en = 1'b1;
    sb.push_back('{cyc + 1 + LAT, 16'hFFFF});
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      tb_c2_en = 1'b0;
      tb_d2    = line_x[i*16 +: 16];
    end
    #2;
    rst_n    = 1'b0;
    tb_d2_en = 1'b0;
    #1;
    check("wr_abort_c2", 32'(c2_w), 32'h0);
    check("wr_abort_d2", 32'(d2_w), 32'hFFFF);
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    cmd_read(10'h3FF, 1'b1);
    wait_idle();

    // Reset during beat 3 of a read, then a read on the first edge after release.
    start = cyc + 1 + LAT;
    cmd_read(10'h005, 1'b1);
    while (cyc < start + 3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rd_abort_c2", 32'(c2_w), 32'h0);
    check("rd_abort_d2", 32'(d2_w), 32'hFFFF);
    sb.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    cmd_read(10'h005, 1'b1);
    wait_idle();

    // NOP then floating C2 for 500 cycles: nothing may respond.
    tb_c2    = 2'b00;
    tb_c2_en = 1'b1;
    repeat (250) @(negedge clk);
    #1;
    tb_c2_en = 1'b0;
    repeat (250) @(negedge clk);
    #1;
    check("quiet_sb", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR2_BUS_SIZE, default 10, line-address width (tag+set bits).
REQ-002 SHALL have parameter DATA_BUS_SIZE, default 16, data bus width (2 bytes per beat).
REQ-003 SHALL have parameter CTR2_BUS_SIZE, default 2, command bus width.
REQ-004 SHALL have parameter CACHE_LINE_SIZE, default 16, bytes per line; BEATS = CACHE_LINE_SIZE/2 = 8.
REQ-005 SHALL have parameter MEM_LATENCY, default 100, cycles from command-sample edge to first response cycle; elaboration SHALL fail if MEM_LATENCY < BEATS+1.
REQ-006 SHALL have port CLK  input  1  single clock, all state on posedge.
REQ-007 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port A2_WIRE  input  ADDR2_BUS_SIZE  line address from cache.
REQ-009 SHALL have port D2_WIRE  inout  DATA_BUS_SIZE  data; D2[7:0] = even-offset byte, D2[15:8] = odd-offset byte.
REQ-010 SHALL have port C2_WIRE  inout  CTR2_BUS_SIZE  command/response.
REQ-011 SHALL use encodings C2_NOP=2'b00, C2_RESPONSE=2'b01, C2_READ_LINE=2'b10, C2_WRITE_LINE=2'b11.

Function
REQ-012 SHALL store 2^ADDR2_BUS_SIZE lines x BEATS 16-bit words; array contents SHALL NOT be altered by reset.
REQ-013 SHALL use states IDLE, WR_RX, WAIT, RD_TX, WR_ACK.
REQ-014 IDLE: at posedge with C2_WIRE==C2_READ_LINE, latch A2_WIRE, load latency counter, go WAIT (read).
REQ-015 IDLE: at posedge with C2_WIRE==C2_WRITE_LINE, latch A2_WIRE and D2_WIRE as beat 0 into line buffer, go WR_RX.
REQ-016 IDLE: any other C2_WIRE value (NOP, RESPONSE, X, Z) SHALL be ignored.
REQ-017 WR_RX: capture D2_WIRE as beats 1..BEATS-1 on the BEATS-1 following posedges; after last beat, commit whole buffer to array in one write, go WAIT (write).
REQ-018 Latency counter SHALL decrement every cycle from command-sample edge (counted in WR_RX too); response SHALL begin exactly MEM_LATENCY cycles after the command-sample edge.
REQ-019 RD_TX: drive C2=C2_RESPONSE and D2=beat i for cycle i, i=0..BEATS-1, beat 0 in first response cycle; read data SHALL come from array at latched address.
REQ-020 WR_ACK: drive C2=C2_RESPONSE for exactly one cycle; D2 SHALL stay high-Z.
REQ-021 After last RD_TX beat or WR_ACK cycle, C2 and D2 SHALL be high-Z next cycle and state SHALL return to IDLE; new command accepted from the following posedge.
REQ-022 Outside RD_TX/WR_ACK, C2_WIRE and D2_WIRE drivers SHALL be high-Z.
REQ-023 Commands arriving in non-IDLE states SHALL be ignored, no queueing.
REQ-024 Read of a line written earlier SHALL return committed bytes byte-exact, including read issued on the cycle after WR_ACK.

Reset
REQ-025 RESET_N low SHALL immediately high-Z C2/D2, force IDLE, clear counter, beat index and latched address.
REQ-026 Reset during WR_RX or WAIT(write) before commit SHALL discard line buffer; array unchanged.
REQ-027 Reset during RD_TX SHALL abort transfer with no further beats after release.
REQ-028 First command SHALL be accepted on the first posedge after RESET_N deasserts.

Verification
REQ-029 WRITE_LINE A2=10'h005, beats 16'h0100,16'h0302,...,16'h0F0E -> C2_RESPONSE single cycle exactly 100 cycles after command edge, buses Z afterwards.
REQ-030 READ_LINE A2=10'h005 after REQ-029 -> at +100 cycles, 8 consecutive beats 16'h0100..16'h0F0E with C2=RESPONSE, then Z.
REQ-031 READ_LINE issued during WAIT of another command -> ignored, only original response observed.
REQ-032 RESET_N low at beat 4 of WRITE_LINE to 10'h3FF -> buses Z at once; later READ_LINE 10'h3FF returns prior contents.
REQ-033 RESET_N low during RD_TX beat 3 -> C2/D2 Z same time step; READ_LINE on first edge after release accepted, full 8 beats at +100.
REQ-034 C2_WIRE held Z or C2_NOP for 500 cycles -> no response, buses remain Z.
